bf_op_unit: RTL and testbench

Radix-2 complex butterfly for the pipelined FFT/IFFT flow: given complex samples A and B it produces A+B and A−B in the same cycle. It is instantiated once per stage inside the butterfly stage block, which feeds the delay-line sample as A and the incoming sample as B. A registered sticky overflow flag lets the stage or system controller detect arithmetic overflow without altering the datapath.

---
 rtl/bf_op_unit.sv | 102 ++++++++++
 tb/tb_bf_op_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bf_op_unit.sv
// bf_op_unit: radix-2 complex butterfly producing A+B and A-B combinationally.
// Each component sum/difference is formed one bit wider and then reduced to the
// field width. A registered sticky flag records any out-of-range result.
// Build option: define BF_OP_SAT_EN to clamp out-of-range results instead of
// wrapping. Overflow detection is the same in both builds.
module bf_op_unit #(
   parameter int REAL_WIDTH = 18,
   parameter int IMGN_WIDTH = 18
) (
   input  logic                                   iclk,
   input  logic                                   rst,
   input  logic                                   ien,
   input  logic                                   ovf_clr,
   input  logic [REAL_WIDTH+IMGN_WIDTH-1:0]       ia,
   input  logic [REAL_WIDTH+IMGN_WIDTH-1:0]       ib,
   output logic [REAL_WIDTH+IMGN_WIDTH-1:0]       oa,
   output logic [REAL_WIDTH+IMGN_WIDTH-1:0]       ob,
   output logic                                   ovf
);

   localparam int CPLX_WIDTH = REAL_WIDTH + IMGN_WIDTH;

   // A widened result overflows the field when its top two bits disagree.
   function automatic logic ovf_re(input logic signed [REAL_WIDTH:0] v);
      return v[REAL_WIDTH] != v[REAL_WIDTH-1];
   endfunction

   function automatic logic ovf_im(input logic signed [IMGN_WIDTH:0] v);
      return v[IMGN_WIDTH] != v[IMGN_WIDTH-1];
   endfunction

   // Reduce a widened real-part result to the field: wrap or clamp.
   function automatic logic signed [REAL_WIDTH-1:0] reduce_re(input logic signed [REAL_WIDTH:0] v);
      logic signed [REAL_WIDTH-1:0] r;
      r = v[REAL_WIDTH-1:0];
`ifdef BF_OP_SAT_EN
      if (ovf_re(v)) begin
         r = v[REAL_WIDTH] ? {1'b1, {(REAL_WIDTH-1){1'b0}}}
                           : {1'b0, {(REAL_WIDTH-1){1'b1}}};
      end
`endif
      return r;
   endfunction

   // Reduce a widened imaginary-part result to the field: wrap or clamp.
   function automatic logic signed [IMGN_WIDTH-1:0] reduce_im(input logic signed [IMGN_WIDTH:0] v);
      logic signed [IMGN_WIDTH-1:0] r;
      r = v[IMGN_WIDTH-1:0];
`ifdef BF_OP_SAT_EN
      if (ovf_im(v)) begin
         r = v[IMGN_WIDTH] ? {1'b1, {(IMGN_WIDTH-1){1'b0}}}
                           : {1'b0, {(IMGN_WIDTH-1){1'b1}}};
      end
`endif
      return r;
   endfunction

   logic signed [REAL_WIDTH-1:0] a_re, b_re;
   logic signed [IMGN_WIDTH-1:0] a_im, b_im;
   logic signed [REAL_WIDTH:0]   sum_re, dif_re;
   logic signed [IMGN_WIDTH:0]   sum_im, dif_im;
   logic                         ovf_now;
   logic                         ovf_d, ovf_q;

   assign a_re = ia[CPLX_WIDTH-1:IMGN_WIDTH];
   assign a_im = ia[IMGN_WIDTH-1:0];
   assign b_re = ib[CPLX_WIDTH-1:IMGN_WIDTH];
   assign b_im = ib[IMGN_WIDTH-1:0];

   // Widened butterfly arithmetic and reduction back to the field widths.
   always_comb begin
      sum_re  = $signed({a_re[REAL_WIDTH-1], a_re}) + $signed({b_re[REAL_WIDTH-1], b_re});
      dif_re  = $signed({a_re[REAL_WIDTH-1], a_re}) - $signed({b_re[REAL_WIDTH-1], b_re});
      sum_im  = $signed({a_im[IMGN_WIDTH-1], a_im}) + $signed({b_im[IMGN_WIDTH-1], b_im});
      dif_im  = $signed({a_im[IMGN_WIDTH-1], a_im}) - $signed({b_im[IMGN_WIDTH-1], b_im});
      oa      = {reduce_re(sum_re), reduce_im(sum_im)};
      ob      = {reduce_re(dif_re), reduce_im(dif_im)};
      ovf_now = ovf_re(sum_re) | ovf_re(dif_re) | ovf_im(sum_im) | ovf_im(dif_im);
   end

   // Sticky flag next state: clear beats a same-cycle overflow.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end else if (ien && ovf_now) begin
         ovf_d = 1'b1;
      end
   end

   // Sticky overflow register with synchronous reset.
   always_ff @(posedge iclk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;

endmodule

// File: tb/tb_bf_op_unit.sv
// tb_bf_op_unit: directed and randomized checks of bf_op_unit against an
// integer-arithmetic reference. Honours BF_OP_SAT_EN the same way as the design.
module tb_bf_op_unit;

   localparam int RW = 18;
   localparam int IW = 18;
   localparam int CW = RW + IW;

   logic          iclk = 1'b0;
   logic          rst = 1'b1;
   logic          ien = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [CW-1:0] ia = '0;
   logic [CW-1:0] ib = '0;
   logic [CW-1:0] oa, ob;
   logic          ovf;

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  ovf_ref = 1'b0;

   bf_op_unit #(.REAL_WIDTH(RW), .IMGN_WIDTH(IW)) dut (
      .iclk(iclk), .rst(rst), .ien(ien), .ovf_clr(ovf_clr),
      .ia(ia), .ib(ib), .oa(oa), .ob(ob), .ovf(ovf)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reduce an exact integer result to a w-bit field by the build's rule.
   function automatic longint fit(input longint v, input int w, inout bit ov);
      longint mx, mn, m;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -(longint'(1) <<< (w - 1));
      if (v > mx || v < mn) ov = 1'b1;
`ifdef BF_OP_SAT_EN
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
`else
      m = longint'(1) <<< w;
      v = v % m;
      if (v > mx) v = v - m;
      if (v < mn) v = v + m;
      return v;
`endif
   endfunction

   function automatic logic [CW-1:0] pack(input longint re, input longint im);
      logic [63:0] r, i;
      r = re;
      i = im;
      return {r[RW-1:0], i[IW-1:0]};
   endfunction

   task automatic model(input logic [CW-1:0] a, input logic [CW-1:0] b,
                        output logic [CW-1:0] ea, output logic [CW-1:0] eb, output bit ov);
      longint ar, ai, br, bi;
      ar = $signed(a[CW-1:IW]);
      ai = $signed(a[IW-1:0]);
      br = $signed(b[CW-1:IW]);
      bi = $signed(b[IW-1:0]);
      ov = 1'b0;
      ea = pack(fit(ar + br, RW, ov), fit(ai + bi, IW, ov));
      eb = pack(fit(ar - br, RW, ov), fit(ai - bi, IW, ov));
   endtask

   // Apply one cycle of stimulus: check data mid-cycle, then the flag after the edge.
   task automatic step(input string tag, input logic [CW-1:0] a, input logic [CW-1:0] b,
                       input logic en, input logic clr, input logic rs);
      logic [CW-1:0] ea, eb;
      bit ov;
      ia = a; ib = b; ien = en; ovf_clr = clr; rst = rs;
      #1;
      model(a, b, ea, eb, ov);
      chk({tag, ".oa"}, 64'(oa), 64'(ea));
      chk({tag, ".ob"}, 64'(ob), 64'(eb));
      if (rs || clr) ovf_ref = 1'b0;
      else if (en && ov) ovf_ref = 1'b1;
      @(posedge iclk);
      #1;
      chk({tag, ".ovf"}, 64'(ovf), 64'(ovf_ref));
      @(negedge iclk);
   endtask

   function automatic longint corner(input int w);
      case ($urandom_range(0, 5))
         0: return (longint'(1) <<< (w - 1)) - 1;
         1: return -(longint'(1) <<< (w - 1));
         2: return -1;
         3: return 0;
         default: return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w - 1));
      endcase
   endfunction

   localparam longint MX = 131071;
   localparam longint MN = -131072;

   initial begin
      logic [CW-1:0] a, b;
      @(negedge iclk);
      step("reset", '0, '0, 1'b0, 1'b0, 1'b1);
      step("basic", pack(100, -50), pack(30, 20), 1'b1, 1'b0, 1'b0);
      chk("basic.oa_lit", 64'(oa), 64'(pack(130, -30)));
      chk("basic.ob_lit", 64'(ob), 64'(pack(70, -70)));
      chk("basic.ovf_lit", 64'(ovf), 64'(0));
      // Qualification: overflow with ien low leaves the flag clear.
      step("qual", pack(MX, 0), pack(1, 0), 1'b0, 1'b0, 1'b0);
      chk("qual.ovf_lit", 64'(ovf), 64'(0));
      // Positive sum overflow on the real part.
      step("posovf", pack(MX, 0), pack(1, 0), 1'b1, 1'b0, 1'b0);
`ifdef BF_OP_SAT_EN
      chk("posovf.re_lit", 64'(oa[CW-1:IW]), 64'(18'sd131071));
`else
      chk("posovf.re_lit", 64'(oa[CW-1:IW]), 64'(18'h20000));
`endif
      chk("posovf.ovf_lit", 64'(ovf), 64'(1));
      // Clear wins over a same-cycle overflow.
      step("clrwin", pack(0, MN), pack(0, 1), 1'b1, 1'b1, 1'b0);
      chk("clrwin.ovf_lit", 64'(ovf), 64'(0));
      // Negative difference overflow on the imaginary part.
      step("negdif", pack(0, MN), pack(0, 1), 1'b1, 1'b0, 1'b0);
`ifdef BF_OP_SAT_EN
      chk("negdif.im_lit", 64'(ob[IW-1:0]), 64'(18'h20000));
`else
      chk("negdif.im_lit", 64'(ob[IW-1:0]), 64'(18'h1FFFF));
`endif
      chk("negdif.ovf_lit", 64'(ovf), 64'(1));
      step("hold", pack(5, 5), pack(3, 3), 1'b1, 1'b0, 1'b0);
      step("rst", pack(MX, MX), pack(MX, MN), 1'b1, 1'b0, 1'b1);
      chk("rst.ovf_lit", 64'(ovf), 64'(0));
      // Randomized pairs with corner-biased operands and sparse control.
      for (int i = 0; i < 10000; i++) begin
         a = pack(corner(RW), corner(IW));
         b = pack(corner(RW), corner(IW));
         step("rand", a, b, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
